// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption sequencer: owns the 128-bit state, does the initial
// AddRoundKey, then walks the shared inverse-round datapath for NR cycles.
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic [127:0] dp_state,
    output logic         dp_last,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned DW = 128;
    localparam int unsigned KW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [DW-1:0] state_q, state_d;
    logic [KW-1:0] round_q, round_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        if (flush) begin
            fsm_d   = IDLE;
            state_d = '0;
            round_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        fsm_d   = ROUND;
                        state_d = in_data ^ round_key;
                        round_d = KW'(NR - 1);
                    end
                end
                ROUND: begin
                    state_d = dp_result;
                    if (round_q == '0) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q - KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d = IDLE;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    // Outputs; key_idx parks at NR so the key schedule always sees a legal index
    always_comb begin
        in_ready  = (fsm_q == IDLE) && !flush;
        key_idx   = KW'(NR);
        dp_state  = state_q;
        dp_last   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (fsm_q == ROUND) || (fsm_q == DONE);
        if (fsm_q == ROUND) begin
            key_idx = round_q;
            dp_last = (round_q == '0);
        end
        if (fsm_q == DONE) begin
            out_valid = 1'b1;
            out_data  = state_q;
        end
    end

endmodule
